// File: rtl/rgf_writeback_if.sv
`default_nettype none
// ============================================================================
// Module      : rgf_writeback_if
// Description : Bundle of the writeback block's issue, result, decode-check
//               and register-file write signals.
//               Members:
//                 iss_valid/iss_rd                issuing destination
//                 alu_valid/alu_rd/alu_data       ALU result (no backpressure)
//                 lsu_valid/lsu_ready/lsu_rd/lsu_data  LSU result handshake
//                 rs1/rs2/hazard                  decode RAW check
//                 wb_we/wb_wn/wb_data             register-file write port
//                 fwd1_*/fwd2_*                   forwarding (WB_BYPASS_EN)
//               Modport master: the writeback block. Modport slave: its
//               environment (issue, ALU, LSU, decode, register file).
// Revision    : 1.0 - initial release
// ============================================================================
interface rgf_writeback_if #(
    parameter int XLEN = 32
);
    logic            iss_valid;
    logic [4:0]      iss_rd;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            lsu_valid;
    logic            lsu_ready;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            hazard;
    logic            wb_we;
    logic [4:0]      wb_wn;
    logic [XLEN-1:0] wb_data;
`ifdef WB_BYPASS_EN
    logic            fwd1_valid;
    logic            fwd2_valid;
    logic [XLEN-1:0] fwd1_data;
    logic [XLEN-1:0] fwd2_data;

    modport master (
        input  iss_valid, iss_rd, alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data, rs1, rs2,
        output lsu_ready, hazard, wb_we, wb_wn, wb_data,
        output fwd1_valid, fwd2_valid, fwd1_data, fwd2_data
    );
    modport slave (
        output iss_valid, iss_rd, alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data, rs1, rs2,
        input  lsu_ready, hazard, wb_we, wb_wn, wb_data,
        input  fwd1_valid, fwd2_valid, fwd1_data, fwd2_data
    );
`else
    modport master (
        input  iss_valid, iss_rd, alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data, rs1, rs2,
        output lsu_ready, hazard, wb_we, wb_wn, wb_data
    );
    modport slave (
        output iss_valid, iss_rd, alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data, rs1, rs2,
        input  lsu_ready, hazard, wb_we, wb_wn, wb_data
    );
`endif
endinterface
`default_nettype wire

// File: rtl/rgf_writeback.sv
`default_nettype none
// ============================================================================
// Module      : rgf_writeback
// Description : Write-side initiator for the 32x32 register file. Merges the
//               single-cycle ALU result path (strict priority) with LSU
//               results buffered in a FIFO, drives the registered write port,
//               and keeps a pending-destination scoreboard for RAW stalls.
//               Ports:
//                 clk  - clock, rising-edge state updates
//                 rst  - asynchronous active-high reset
//                 bus  - rgf_writeback_if.master (issue, ALU, LSU, decode
//                        check, register-file write port)
//               Optional feature macro: WB_BYPASS_EN adds fwd1/fwd2
//               forwarding outputs and ALU-side hazard suppression.
// Revision    : 1.0 - initial release
// ============================================================================
module rgf_writeback #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    rgf_writeback_if.master     bus
);
    localparam int             c_aw      = $clog2(FIFO_DEPTH);
    localparam logic [c_aw-1:0] c_ptr_one = 1;
    localparam logic [c_aw:0]   c_cnt_one = 1;
    localparam logic [c_aw:0]   c_full    = (c_aw+1)'(FIFO_DEPTH);

    logic [XLEN-1:0] r_fifo_data [FIFO_DEPTH];
    logic [4:0]      r_fifo_rd   [FIFO_DEPTH];
    logic [c_aw-1:0] r_wptr;
    logic [c_aw-1:0] r_rptr;
    logic [c_aw:0]   r_count;
    logic [31:0]     r_pending;
    logic            r_wb_we;
    logic [4:0]      r_wb_wn;
    logic [XLEN-1:0] r_wb_data;

    logic            w_ready;
    logic            w_push;
    logic            w_alu_go;
    logic            w_pop;
    logic [c_aw:0]   w_count_nxt;
    logic            w_we_nxt;
    logic [4:0]      w_wn_nxt;
    logic [XLEN-1:0] w_data_nxt;
    logic [31:0]     w_pending_nxt;
    logic            w_pend1;
    logic            w_pend2;

    // Readiness comes from the registered count only, so a pop in the same
    // cycle never opens a slot early; forced low while reset is asserted.
    assign w_ready  = !rst && (r_count != c_full);
    // An x0 LSU result completes its handshake but is never enqueued.
    assign w_push   = bus.lsu_valid && w_ready && (bus.lsu_rd != 5'd0);
    assign w_alu_go = bus.alu_valid && (bus.alu_rd != 5'd0);
    assign w_pop    = !w_alu_go && (r_count != '0);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + c_cnt_one;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - c_cnt_one;
        end
    end

    // Write-port selection for the next cycle: ALU first, then FIFO head.
    always_comb begin
        w_we_nxt   = 1'b0;
        w_wn_nxt   = r_wb_wn;
        w_data_nxt = r_wb_data;
        if (w_alu_go) begin
            w_we_nxt   = 1'b1;
            w_wn_nxt   = bus.alu_rd;
            w_data_nxt = bus.alu_data;
        end else if (w_pop) begin
            w_we_nxt   = 1'b1;
            w_wn_nxt   = r_fifo_rd[r_rptr];
            w_data_nxt = r_fifo_data[r_rptr];
        end
    end

    // Clear for the launched write first, then apply the issue set so a
    // same-register collision leaves the bit set for the newer instruction.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_we_nxt) begin
            w_pending_nxt[w_wn_nxt] = 1'b0;
        end
        if (bus.iss_valid && (bus.iss_rd != 5'd0)) begin
            w_pending_nxt[bus.iss_rd] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_pending <= '0;
            r_wb_we   <= 1'b0;
            r_wb_wn   <= 5'd0;
            r_wb_data <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
            r_count   <= w_count_nxt;
            r_pending <= w_pending_nxt;
            r_wb_we   <= w_we_nxt;
            r_wb_wn   <= w_wn_nxt;
            r_wb_data <= w_data_nxt;
        end
    end

    // FIFO storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wptr]   <= bus.lsu_rd;
            r_fifo_data[r_wptr] <= bus.lsu_data;
        end
    end

    assign w_pend1 = (bus.rs1 != 5'd0) && r_pending[bus.rs1];
    assign w_pend2 = (bus.rs2 != 5'd0) && r_pending[bus.rs2];

`ifdef WB_BYPASS_EN
    logic w_alu_hit1;
    logic w_alu_hit2;
    logic w_wb_hit1;
    logic w_wb_hit2;

    assign w_alu_hit1 = bus.alu_valid && (bus.rs1 != 5'd0) && (bus.alu_rd == bus.rs1);
    assign w_alu_hit2 = bus.alu_valid && (bus.rs2 != 5'd0) && (bus.alu_rd == bus.rs2);
    assign w_wb_hit1  = r_wb_we && (bus.rs1 != 5'd0) && (r_wb_wn == bus.rs1);
    assign w_wb_hit2  = r_wb_we && (bus.rs2 != 5'd0) && (r_wb_wn == bus.rs2);

    // The in-flight ALU value is newer than the one being written, so it wins.
    assign bus.fwd1_valid = w_alu_hit1 || w_wb_hit1;
    assign bus.fwd2_valid = w_alu_hit2 || w_wb_hit2;
    assign bus.fwd1_data  = w_alu_hit1 ? bus.alu_data : r_wb_data;
    assign bus.fwd2_data  = w_alu_hit2 ? bus.alu_data : r_wb_data;
    assign bus.hazard     = (w_pend1 && !w_alu_hit1) || (w_pend2 && !w_alu_hit2);
`else
    assign bus.hazard     = w_pend1 || w_pend2;
`endif

    assign bus.lsu_ready = w_ready;
    assign bus.wb_we     = r_wb_we;
    assign bus.wb_wn     = r_wb_wn;
    assign bus.wb_data   = r_wb_data;

endmodule
`default_nettype wire

// File: tb/tb_rgf_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_rgf_writeback
// Description : Self-checking bench for rgf_writeback. Per-cycle directed
//               vectors (inputs plus expected post-edge outputs) cover
//               latency, arbitration, FIFO fill/wrap, x0 and scoreboard
//               collision; hand-written sequences cover reset release and
//               an asynchronous reset with the FIFO part full.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rgf_writeback;
    logic clk;
    logic rst;

    rgf_writeback_if #(.XLEN(32)) bus ();

    rgf_writeback #(
        .XLEN       (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [4:0]  ird;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldata;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        we;
        logic [4:0]  wn;
        logic [31:0] wdata;
        logic        rdy;
        logic        haz;
    } vec_t;

    vec_t vecs[$];
    int   n_chk;
    int   n_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [4:0] ird,
                       input logic av, input logic [4:0] ard, input logic [31:0] adata,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic we, input logic [4:0] wn, input logic [31:0] wdata,
                       input logic rdy, input logic haz);
        vec_t v;
        v.iv = iv; v.ird = ird; v.av = av; v.ard = ard; v.adata = adata;
        v.lv = lv; v.lrd = lrd; v.ldata = ldata; v.rs1 = rs1; v.rs2 = rs2;
        v.we = we; v.wn = wn; v.wdata = wdata; v.rdy = rdy; v.haz = haz;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic iv, input logic [4:0] ird,
                         input logic av, input logic [4:0] ard, input logic [31:0] adata,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
                         input logic [4:0] rs1, input logic [4:0] rs2);
        bus.iss_valid = iv;  bus.iss_rd   = ird;
        bus.alu_valid = av;  bus.alu_rd   = ard; bus.alu_data = adata;
        bus.lsu_valid = lv;  bus.lsu_rd   = lrd; bus.lsu_data = ldata;
        bus.rs1       = rs1; bus.rs2      = rs2;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst   = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        //   iv ird av ard adata         lv lrd ldata      rs1 rs2  we wn wdata         rdy haz
        add(1, 5,  0, 0, 32'h0,         0, 0,  32'h0,     5, 0,    0, 0, 32'h0,         1, 1);
        add(0, 0,  1, 5, 32'hDEADBEEF,  0, 0,  32'h0,     5, 0,    1, 5, 32'hDEADBEEF,  1, 0);
        add(0, 0,  0, 0, 32'h0,         0, 0,  32'h0,     5, 0,    0, 0, 32'h0,         1, 0);
        add(0, 0,  1, 3, 32'h11,        1, 4,  32'h22,    0, 0,    1, 3, 32'h11,        1, 0);
        add(0, 0,  0, 0, 32'h0,         0, 0,  32'h0,     0, 0,    1, 4, 32'h22,        1, 0);
        add(0, 0,  0, 0, 32'h0,         0, 0,  32'h0,     0, 0,    0, 0, 32'h0,         1, 0);
        add(0, 0,  1, 1, 32'hA1,        1, 8,  32'h88,    0, 0,    1, 1, 32'hA1,        1, 0);
        add(0, 0,  1, 1, 32'hA2,        1, 9,  32'h99,    0, 0,    1, 1, 32'hA2,        1, 0);
        add(0, 0,  1, 1, 32'hA3,        1, 10, 32'hAA,    0, 0,    1, 1, 32'hA3,        1, 0);
        add(0, 0,  1, 1, 32'hA4,        1, 11, 32'hBB,    0, 0,    1, 1, 32'hA4,        0, 0);
        add(0, 0,  1, 1, 32'hA5,        1, 12, 32'hCC,    0, 0,    1, 1, 32'hA5,        0, 0);
        add(0, 0,  1, 1, 32'hA6,        1, 12, 32'hCC,    0, 0,    1, 1, 32'hA6,        0, 0);
        add(0, 0,  0, 0, 32'h0,         1, 12, 32'hCC,    0, 0,    1, 8, 32'h88,        1, 0);
        add(0, 0,  0, 0, 32'h0,         1, 12, 32'hCC,    0, 0,    1, 9, 32'h99,        1, 0);
        add(0, 0,  0, 0, 32'h0,         0, 0,  32'h0,     0, 0,    1, 10, 32'hAA,       1, 0);
        add(0, 0,  0, 0, 32'h0,         0, 0,  32'h0,     0, 0,    1, 11, 32'hBB,       1, 0);
        add(0, 0,  0, 0, 32'h0,         0, 0,  32'h0,     0, 0,    1, 12, 32'hCC,       1, 0);
        add(0, 0,  0, 0, 32'h0,         0, 0,  32'h0,     0, 0,    0, 0, 32'h0,         1, 0);
        add(1, 6,  0, 0, 32'h0,         0, 0,  32'h0,     6, 0,    0, 0, 32'h0,         1, 1);
        add(0, 0,  1, 0, 32'h55,        1, 0,  32'h66,    6, 0,    0, 0, 32'h0,         1, 1);
        add(0, 0,  0, 0, 32'h0,         0, 0,  32'h0,     6, 0,    0, 0, 32'h0,         1, 1);
        add(0, 0,  1, 6, 32'h60,        0, 0,  32'h0,     6, 0,    1, 6, 32'h60,        1, 0);
        add(1, 7,  0, 0, 32'h0,         0, 0,  32'h0,     7, 0,    0, 0, 32'h0,         1, 1);
        add(1, 7,  1, 7, 32'h70,        0, 0,  32'h0,     0, 0,    1, 7, 32'h70,        1, 0);
        add(0, 0,  0, 0, 32'h0,         0, 0,  32'h0,     7, 0,    0, 0, 32'h0,         1, 1);
        add(0, 0,  1, 7, 32'h71,        0, 0,  32'h0,     0, 7,    1, 7, 32'h71,        1, 0);
        add(1, 9,  0, 0, 32'h0,         0, 0,  32'h0,     0, 9,    0, 0, 32'h0,         1, 1);
        add(0, 0,  0, 0, 32'h0,         1, 9,  32'h99,    0, 9,    0, 0, 32'h0,         1, 1);
        add(0, 0,  0, 0, 32'h0,         0, 0,  32'h0,     0, 9,    1, 9, 32'h99,        1, 0);

        // Reset held: everything quiet, LSU not ready.
        repeat (3) @(posedge clk);
        #1;
        check("rst_we",    {31'd0, bus.wb_we},     32'd0);
        check("rst_wn",    {27'd0, bus.wb_wn},     32'd0);
        check("rst_data",  bus.wb_data,            32'd0);
        check("rst_haz",   {31'd0, bus.hazard},    32'd0);
        check("rst_ready", {31'd0, bus.lsu_ready}, 32'd0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_ready", {31'd0, bus.lsu_ready}, 32'd1);
        check("rel_we",    {31'd0, bus.wb_we},     32'd0);
        check("rel_haz",   {31'd0, bus.hazard},    32'd0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].iv, vecs[i].ird, vecs[i].av, vecs[i].ard, vecs[i].adata,
                  vecs[i].lv, vecs[i].lrd, vecs[i].ldata, vecs[i].rs1, vecs[i].rs2);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_we", i),    {31'd0, bus.wb_we},     {31'd0, vecs[i].we});
            check($sformatf("v%0d_ready", i), {31'd0, bus.lsu_ready}, {31'd0, vecs[i].rdy});
            check($sformatf("v%0d_haz", i),   {31'd0, bus.hazard},    {31'd0, vecs[i].haz});
            if (vecs[i].we) begin
                check($sformatf("v%0d_wn", i),   {27'd0, bus.wb_wn}, {27'd0, vecs[i].wn});
                check($sformatf("v%0d_data", i), bus.wb_data,        vecs[i].wdata);
            end
        end

        // Async reset with three LSU results buffered and x10/x11 pending.
        @(negedge clk);
        drive(1, 10, 1, 1, 32'h1, 1, 13, 32'hD13, 0, 0);
        @(negedge clk);
        drive(1, 11, 1, 1, 32'h2, 1, 14, 32'hD14, 0, 0);
        @(negedge clk);
        drive(0, 0, 1, 1, 32'h3, 1, 15, 32'hD15, 10, 11);
        @(posedge clk);
        #1;
        check("pre_we",    {31'd0, bus.wb_we},     32'd1);
        check("pre_haz",   {31'd0, bus.hazard},    32'd1);
        check("pre_ready", {31'd0, bus.lsu_ready}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_we",    {31'd0, bus.wb_we},     32'd0);
        check("arst_wn",    {27'd0, bus.wb_wn},     32'd0);
        check("arst_data",  bus.wb_data,            32'd0);
        check("arst_haz",   {31'd0, bus.hazard},    32'd0);
        check("arst_ready", {31'd0, bus.lsu_ready}, 32'd0);

        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 10, 11);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("post%0d_we", k),    {31'd0, bus.wb_we},     32'd0);
            check($sformatf("post%0d_haz", k),   {31'd0, bus.hazard},    32'd0);
            check($sformatf("post%0d_ready", k), {31'd0, bus.lsu_ready}, 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
